// File: rtl/out_reader_pkg.sv
// Shared sizing and state encoding for the output reader; values match the network top.
package out_reader_pkg;

    localparam int unsigned NEURONS   = 8;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned INT_BITS  = 6;
    localparam int unsigned FRAC_BITS = 10;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/out_reader_argmax_step.sv
// One step of a running argmax: keeps the incumbent unless the new word is strictly larger (signed).
module fx_argmax_step
    import out_reader_pkg::*;
#(
    parameter int unsigned n    = WORD_W,
    parameter int unsigned IDXW = IDX_W
) (
    input  logic [n-1:0]    run_max,
    input  logic [IDXW-1:0] run_idx,
    input  logic [n-1:0]    word,
    input  logic [IDXW-1:0] idx,
    output logic [n-1:0]    max_c,
    output logic [IDXW-1:0] idx_c
);

    logic take;

    // Strict compare so ties keep the earlier (lower) index.
    always_comb begin
        take  = $signed(word) > $signed(run_max);
        max_c = take ? word : run_max;
        idx_c = take ? idx  : run_idx;
    end

endmodule

// File: rtl/out_reader.sv
// Captures a completed frame of neuron outputs, streams it word by word over a
// valid/ready port and reports the argmax of the frame once it has been drained.
module out_reader
    import out_reader_pkg::*;
#(
    parameter int unsigned N    = NEURONS,
    parameter int unsigned n    = WORD_W,
    parameter int unsigned IDXW = IDX_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N*n-1:0]  Y,
    input  logic            y_valid,
    output logic [n-1:0]    out_data,
    output logic [IDXW-1:0] out_idx,
    output logic            out_valid,
    output logic            out_last,
    input  logic            out_ready,
    output logic [IDXW-1:0] class_idx,
    output logic [n-1:0]    class_max,
    output logic            class_valid,
    output logic            overrun
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_t          state;
    logic [N*n-1:0]  frame_buf;
    logic [n-1:0]    run_max;
    logic [IDXW-1:0] run_idx;

    logic            xfer;
    logic            capture;
    logic [IDXW-1:0] idx_nxt;
    logic [n-1:0]    step_max;
    logic [IDXW-1:0] step_idx;
    logic [n-1:0]    new_max;
    logic [IDXW-1:0] new_idx;

    fx_argmax_step #(
        .n    (n),
        .IDXW (IDXW)
    ) u_step (
        .run_max (run_max),
        .run_idx (run_idx),
        .word    (out_data),
        .idx     (out_idx),
        .max_c   (step_max),
        .idx_c   (step_idx)
    );

    // Handshake decode and argmax candidate; index 0 seeds the running maximum.
    always_comb begin
        xfer    = out_valid & out_ready;
        capture = y_valid & ((state == ST_IDLE) | (state == ST_DONE));
        idx_nxt = out_idx + IDXW'(1);
        if (out_idx == '0) begin
            new_max = out_data;
            new_idx = '0;
        end else begin
            new_max = step_max;
            new_idx = step_idx;
        end
    end

    // FSM, frame buffer and all output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            frame_buf   <= '0;
            run_max     <= '0;
            run_idx     <= '0;
            out_data    <= '0;
            out_idx     <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            class_idx   <= '0;
            class_max   <= '0;
            class_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            class_valid <= 1'b0;
            if (capture) begin
                // Frame accepted in IDLE or in the DONE cycle of the previous frame.
                frame_buf <= Y;
                out_data  <= Y[n-1:0];
                out_idx   <= '0;
                out_valid <= 1'b1;
                out_last  <= (N == 1);
                state     <= ST_STREAM;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_STREAM: begin
                        if (y_valid) begin
                            overrun <= 1'b1;
                        end
                        if (xfer) begin
                            run_max <= new_max;
                            run_idx <= new_idx;
                            if (out_idx == LAST_IDX) begin
                                // Result is published during the single DONE cycle.
                                out_valid   <= 1'b0;
                                out_last    <= 1'b0;
                                class_idx   <= new_idx;
                                class_max   <= new_max;
                                class_valid <= 1'b1;
                                state       <= ST_DONE;
                            end else begin
                                out_idx  <= idx_nxt;
                                out_data <= frame_buf[idx_nxt*n +: n];
                                out_last <= (idx_nxt == LAST_IDX);
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_out_reader.sv
// Randomized scoreboard bench for out_reader: stimulus pushes expected words and
// argmax results, a negedge monitor pops and compares whatever the DUT presents.
module tb_out_reader;

    localparam int N = 8;
    localparam int W = 16;

    logic           clk;
    logic           reset;
    logic [N*W-1:0] Y;
    logic           y_valid;
    logic [W-1:0]   out_data;
    logic [2:0]     out_idx;
    logic           out_valid;
    logic           out_last;
    logic           out_ready;
    logic [2:0]     class_idx;
    logic [W-1:0]   class_max;
    logic           class_valid;
    logic           overrun;

    out_reader dut (
        .clk         (clk),
        .reset       (reset),
        .Y           (Y),
        .y_valid     (y_valid),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .class_idx   (class_idx),
        .class_max   (class_max),
        .class_valid (class_valid),
        .overrun     (overrun)
    );

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic        last;
    } word_t;

    typedef struct {
        int          idx;
        logic [15:0] max;
    } cls_t;

    word_t exp_q[$];
    cls_t  cls_q[$];
    int    checks = 0;
    int    errors = 0;
    int    mode   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: stream is the frame in index order; argmax is the first index holding the signed maximum.
    task automatic expect_frame(input logic [N*W-1:0] y);
        logic [N*W-1:0] v;
        logic [15:0]    w;
        int             best;
        int             best_val;
        v = y;
        best = 0;
        best_val = int'($signed(v[15:0]));
        for (int i = 0; i < N; i++) begin
            w = v[i*W +: W];
            exp_q.push_back('{idx: i, data: w, last: (i == N - 1)});
            if (int'($signed(w)) > best_val) begin
                best_val = int'($signed(w));
                best = i;
            end
        end
        cls_q.push_back('{idx: best, max: v[best*W +: W]});
    endtask

    task automatic send_frame(input logic [N*W-1:0] y);
        int n_wait;
        n_wait = 0;
        while (out_valid && n_wait < 200) begin
            step();
            n_wait++;
        end
        if (out_valid) begin
            errors++;
            $display("FAIL idle_wait actual=busy required=idle");
        end
        Y = y;
        y_valid = 1'b1;
        expect_frame(y);
        step();
        y_valid = 1'b0;
        Y = {$urandom, $urandom, $urandom, $urandom};
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("latency_idx", 32'(out_idx), 32'd0);
        chk("latency_data", 32'(out_data), 32'(y[15:0]));
    endtask

    task automatic wait_done();
        int n_wait;
        n_wait = 0;
        while ((exp_q.size() != 0 || cls_q.size() != 0) && n_wait < 400) begin
            step();
            n_wait++;
        end
        chk("drain_words", 32'(exp_q.size()), 32'd0);
        chk("drain_class", 32'(cls_q.size()), 32'd0);
    endtask

    task automatic wait_idx(input int idx);
        int n_wait;
        n_wait = 0;
        while (!(out_valid && int'(out_idx) == idx) && n_wait < 100) begin
            step();
            n_wait++;
        end
        chk("reach_idx", 32'(out_idx), 32'(idx));
    endtask

    // Reset with y_valid held high; the capture request must be ignored.
    task automatic do_reset();
        reset = 1'b0;
        y_valid = 1'b1;
        Y = {$urandom, $urandom, $urandom, $urandom};
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_class_idx", 32'(class_idx), 32'd0);
        chk("rst_class_max", 32'(class_max), 32'd0);
        chk("rst_class_valid", 32'(class_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        exp_q.delete();
        cls_q.delete();
        y_valid = 1'b0;
        reset = 1'b1;
        step();
        chk("post_rst_idle", 32'(out_valid), 32'd0);
    endtask

    function automatic logic [N*W-1:0] fill(input logic [15:0] w);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = w;
        return v;
    endfunction

    // Ready pattern generator: 0 = always ready, 1 = 1,0,0 repeating, else random.
    initial begin
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: transfers, stall stability and class_valid timing.
    initial begin
        logic       prev_stall;
        logic       prev_last;
        logic [2:0] st_idx;
        logic [15:0] st_data;
        word_t      ew;
        cls_t       ec;
        prev_stall = 1'b0;
        prev_last  = 1'b0;
        st_idx     = '0;
        st_data    = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                prev_stall = 1'b0;
                prev_last  = 1'b0;
            end else begin
                chk("class_valid_timing", 32'(class_valid), 32'(prev_last));
                if (class_valid === 1'b1) begin
                    if (cls_q.size() == 0) begin
                        errors++;
                        $display("FAIL class_unexpected actual=%0d/%0h required=none", class_idx, class_max);
                    end else begin
                        ec = cls_q.pop_front();
                        chk("class_idx", 32'(class_idx), 32'(ec.idx));
                        chk("class_max", 32'(class_max), 32'(ec.max));
                    end
                end
                if (prev_stall) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_idx", 32'(out_idx), 32'(st_idx));
                    chk("stall_data", 32'(out_data), 32'(st_data));
                end
                prev_stall = 1'b0;
                prev_last  = 1'b0;
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL word_unexpected actual=%0d/%0h required=none", out_idx, out_data);
                    end else begin
                        ew = exp_q.pop_front();
                        chk("word_idx", 32'(out_idx), 32'(ew.idx));
                        chk("word_data", 32'(out_data), 32'(ew.data));
                        chk("word_last", 32'(out_last), 32'(ew.last));
                    end
                    prev_last = out_last;
                end else if (out_valid === 1'b1) begin
                    prev_stall = 1'b1;
                    st_idx     = out_idx;
                    st_data    = out_data;
                end
            end
        end
    end

    initial begin
        logic [N*W-1:0] f;
        logic [15:0]    vals [4];
        reset   = 1'b0;
        y_valid = 1'b0;
        Y       = '0;
        vals[0] = 16'h0400;
        vals[1] = 16'hFC00;
        vals[2] = 16'h0000;
        vals[3] = 16'h7FFF;

        do_reset();

        // All 1.0: ties keep index 0.
        mode = 0;
        send_frame(fill(16'h0400));
        wait_done();

        // Positive peak at 5, negative at 2.
        f = fill(16'h0000);
        f[5*W +: W] = 16'h0C00;
        f[2*W +: W] = 16'hF400;
        send_frame(f);
        wait_done();

        // All negative: signed compare must pick -0.5 at 6.
        f = fill(16'hFC00);
        f[6*W +: W] = 16'hFE00;
        send_frame(f);
        wait_done();

        // Same peak frame under a 1,0,0 ready pattern.
        mode = 1;
        f = fill(16'h0000);
        f[5*W +: W] = 16'h0C00;
        f[2*W +: W] = 16'hF400;
        send_frame(f);
        wait_done();

        // Overrun mid-stream, then capture during DONE.
        mode = 0;
        chk("overrun_clear", 32'(overrun), 32'd0);
        for (int i = 0; i < N; i++) f[i*W +: W] = 16'(i * 16'h0100 + 16'h0011);
        send_frame(f);
        wait_idx(3);
        Y = fill(16'h7FFF);
        y_valid = 1'b1;
        step();
        y_valid = 1'b0;
        chk("overrun_set", 32'(overrun), 32'd1);
        begin
            int n_wait;
            n_wait = 0;
            while (out_valid && n_wait < 50) begin
                step();
                n_wait++;
            end
        end
        chk("done_pulse", 32'(class_valid), 32'd1);
        f = fill(16'h0123);
        f[3*W +: W] = 16'h0200;
        send_frame(f);
        wait_done();
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a frame, then a clean frame.
        f = fill(16'h0800);
        send_frame(f);
        wait_idx(4);
        do_reset();
        repeat (3) step();
        f = fill(16'hFFFF);
        f[7*W +: W] = 16'h0001;
        send_frame(f);
        wait_done();

        // Randomized frames, random ready, some back-to-back.
        mode = 2;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < N; i++) begin
                if (k % 2 == 0) f[i*W +: W] = 16'($urandom);
                else            f[i*W +: W] = vals[$urandom_range(0, 3)];
            end
            send_frame(f);
            if ($urandom_range(0, 1) == 1) wait_done();
        end
        wait_done();
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/out_reader.md
OUT_READER -- requirements
Module: out_reader

Interface
REQ-001 Parameter N, default 8, number of output neurons per frame.
REQ-002 Parameter n, default 16, word width; signed two's complement fixed point, 6 integer bits, 10 fraction bits.
REQ-003 Parameter IDXW, default 3, index width; equals ceil(log2(N)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 Y  input  N*n  final neuron outputs; element i = Y[i*n +: n].
REQ-007 y_valid  input  1  one-cycle strobe; Y holds a completed frame.
REQ-008 out_data  output  n  current streamed element.
REQ-009 out_idx  output  IDXW  index of out_data.
REQ-010 out_valid  output  1  out_data/out_idx valid.
REQ-011 out_last  output  1  high with out_valid when out_idx = N-1.
REQ-012 out_ready  input  1  downstream accepts the word when high with out_valid.
REQ-013 class_idx  output  IDXW  argmax index of last completed frame.
REQ-014 class_max  output  n  value at class_idx.
REQ-015 class_valid  output  1  one-cycle pulse when class_idx/class_max update.
REQ-016 overrun  output  1  sticky; a frame was dropped.

Function
REQ-017 FSM states IDLE, STREAM, DONE; reset enters IDLE.
REQ-018 IDLE: y_valid=1 captures all of Y into an internal N*n frame buffer; next cycle state STREAM, out_valid=1, out_idx=0.
REQ-019 Capture latency: y_valid at cycle t -> first word visible at t+1.
REQ-020 STREAM: out_data = buffer element out_idx; out_data/out_idx/out_valid held stable while out_ready=0.
REQ-021 Transfer occurs on cycle with out_valid=1 and out_ready=1; out_idx increments by 1 on each non-final transfer.
REQ-022 Transfer with out_idx = N-1 -> state DONE, out_valid=0 next cycle.
REQ-023 Running argmax: on transfer of index 0, run_max = word, run_idx = 0; on later transfers replace only if word > run_max, signed compare (ties keep lower index).
REQ-024 DONE (exactly one cycle): class_idx = run_idx, class_max = run_max, class_valid = 1; next state IDLE.
REQ-025 DONE with y_valid=1: capture Y, next state STREAM with out_idx=0 (back-to-back frames; class_valid still pulses).
REQ-026 STREAM with y_valid=1: Y ignored, buffer unchanged, overrun set to 1 and held until reset.
REQ-027 class_idx/class_max hold their values between DONE cycles.
REQ-028 Y ignored whenever y_valid=0; buffer changes only on capture.
REQ-029 Full streaming frame with out_ready held high: N cycles of out_valid, then one DONE cycle.

Reset
REQ-030 reset=0 at a rising edge: state IDLE, out_valid=0, out_idx=0, out_data=0, out_last=0, class_idx=0, class_max=0, class_valid=0, overrun=0, run_max=0, run_idx=0, buffer=0.
REQ-031 Reset mid-STREAM aborts the frame; no class_valid pulse for the aborted frame.
REQ-032 y_valid is ignored during the reset cycle.

Structure
REQ-033 N, n, IDXW, and the integer/fraction bit counts are taken from the shared project defines header (same values as the network top).
REQ-034 One sub-module, fx_argmax_step: combinational signed compare-and-select of (run_max, run_idx) against (word, idx).
REQ-035 Frame buffer, FSM, and output registers live in out_reader.

Verification
REQ-036 Y = {16'h0400 x8} (all 1.0), y_valid pulse, out_ready=1 -> indices 0..7 streamed on consecutive cycles, out_last on idx 7; class_idx=0, class_max=16'h0400, class_valid pulse one cycle after last transfer.
REQ-037 Element 5 = 16'h0C00 (3.0), element 2 = 16'hF400 (-3.0), others 16'h0000 -> class_idx=5, class_max=16'h0C00.
REQ-038 All elements negative (-1.0 = 16'hFC00), except element 6 = 16'hFE00 (-0.5) -> class_idx=6, class_max=16'hFE00 (signed compare check).
REQ-039 out_ready toggled 1,0,0,1,... -> out_data/out_idx hold during stalls; exactly 8 transfers; argmax result identical to the no-stall run.
REQ-040 Second y_valid at stream idx 3 -> overrun=1 and stays 1; streamed data equals the first frame. A third y_valid in DONE is captured and streamed immediately.
REQ-041 reset=0 asserted at stream idx 4 -> all outputs at reset values next cycle; no class_valid pulse; a new frame then streams normally.
